// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, drives an asynchronous ROM, buffers fetched
// words in a 2-entry queue toward decode, and time-shares the ROM with a debug read port.
module instr_fetch_ctrl #(
  parameter int          ADDR_W   = 10,
  parameter int          DATA_W   = 32,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic              CLK,
  input  logic              RST,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] instr,
  output logic [31:0]       instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_data
);

  typedef enum logic {FETCH, ACK} state_t;

  state_t            state_reg, state_next;
  logic [31:0]       pc_reg, pc_next;
  logic [1:0]        count_reg, count_next;
  logic              rd_ptr_reg, rd_ptr_next;
  logic              wr_ptr_reg, wr_ptr_next;
  logic [DATA_W-1:0] dbg_data_reg;
  logic              dbg_grant;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] slot_data [2];
  logic [31:0]       slot_pc   [2];
  logic              unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Debug may only win the ROM from FETCH, so grants are never back to back.
  assign dbg_grant   = (state_reg == FETCH) && dbg_req;
  assign rom_addr    = dbg_grant ? dbg_addr : pc_reg[ADDR_W+1:2];
  assign instr_valid = (count_reg != 2'd0);
  assign pop         = instr_valid && instr_ready;
  assign push        = !dbg_grant && !redirect && ((count_reg != 2'd2) || pop);

  // A reset arriving while the ack is pending cancels that ack.
  assign dbg_ack  = (state_reg == ACK) && !RST;
  assign dbg_data = dbg_data_reg;

  assign instr    = slot_data[rd_ptr_reg];
  assign instr_pc = slot_pc[rd_ptr_reg];

  for (genvar gi = 0; gi < 2; gi++) begin : g_slot
    logic [DATA_W-1:0] data_reg;
    logic [31:0]       pc_reg_q;

    always_ff @(posedge CLK) begin
      if (RST) begin
        data_reg <= '0;
        pc_reg_q <= '0;
      end else if (push && (wr_ptr_reg == 1'(gi))) begin
        data_reg <= rom_data;
        pc_reg_q <= pc_reg;
      end
    end

    assign slot_data[gi] = data_reg;
    assign slot_pc[gi]   = pc_reg_q;
  end

  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    count_next  = count_reg;
    rd_ptr_next = rd_ptr_reg ^ pop;
    wr_ptr_next = wr_ptr_reg;

    case (state_reg)
      FETCH:   state_next = dbg_req ? ACK : FETCH;
      ACK:     state_next = FETCH;
      default: state_next = FETCH;
    endcase

    if (redirect) begin
      // Empty the queue by aligning the write pointer to the (post-pop) head.
      pc_next     = {redirect_pc[31:2], 2'b00};
      count_next  = 2'd0;
      wr_ptr_next = rd_ptr_reg ^ pop;
    end else begin
      if (push) begin
        pc_next     = pc_reg + 32'd4;
        wr_ptr_next = ~wr_ptr_reg;
      end
      case ({push, pop})
        2'b10:   count_next = count_reg + 2'd1;
        2'b01:   count_next = count_reg - 2'd1;
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg    <= FETCH;
      pc_reg       <= {RESET_PC[31:2], 2'b00};
      count_reg    <= 2'd0;
      rd_ptr_reg   <= 1'b0;
      wr_ptr_reg   <= 1'b0;
      dbg_data_reg <= '0;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      count_reg  <= count_next;
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      if (dbg_grant) begin
        dbg_data_reg <= rom_data;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Scoreboard bench for instr_fetch_ctrl: directed cycle table drives fetch, redirect,
// debug and reset; monitors compare delivered instructions and debug reads against queues.
module tb_instr_fetch_ctrl;

  logic        clk = 1'b0;
  logic        RST;
  logic [9:0]  rom_addr;
  logic [31:0] rom_data;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        dbg_req;
  logic [9:0]  dbg_addr;
  logic        dbg_ack;
  logic [31:0] dbg_data;

  logic [3:0]  w_rom_addr;
  logic [31:0] w_rom_data;
  logic [31:0] w_instr;
  logic [31:0] w_instr_pc;
  logic        w_valid;
  logic        w_ready = 1'b1;
  logic        w_redirect = 1'b0;
  logic [31:0] w_redirect_pc = 32'h0;
  logic        w_dbg_req = 1'b0;
  logic [3:0]  w_dbg_addr = 4'h0;
  logic        w_dbg_ack;
  logic [31:0] w_dbg_data;

  logic [31:0] rom  [1024];
  logic [31:0] rom2 [16];

  logic [63:0] exp_q [$];
  logic [31:0] dbg_q [$];
  logic [63:0] wexp_q [$];

  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;

  always #5 clk = ~clk;

  assign rom_data   = rom[rom_addr];
  assign w_rom_data = rom2[w_rom_addr];

  instr_fetch_ctrl #(.ADDR_W(10), .DATA_W(32), .RESET_PC(32'h0)) dut (
    .CLK(clk), .RST(RST), .rom_addr(rom_addr), .rom_data(rom_data),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .redirect(redirect), .redirect_pc(redirect_pc), .dbg_req(dbg_req), .dbg_addr(dbg_addr),
    .dbg_ack(dbg_ack), .dbg_data(dbg_data)
  );

  instr_fetch_ctrl #(.ADDR_W(4), .DATA_W(32), .RESET_PC(32'h3C)) u_wrap (
    .CLK(clk), .RST(RST), .rom_addr(w_rom_addr), .rom_data(w_rom_data),
    .instr(w_instr), .instr_pc(w_instr_pc), .instr_valid(w_valid), .instr_ready(w_ready),
    .redirect(w_redirect), .redirect_pc(w_redirect_pc), .dbg_req(w_dbg_req), .dbg_addr(w_dbg_addr),
    .dbg_ack(w_dbg_ack), .dbg_data(w_dbg_data)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every completed handshake or debug ack consumes one expected entry.
  always @(negedge clk) begin
    if (mon_en) begin
      if (instr_valid && instr_ready) begin
        if (exp_q.size() == 0) check("instr_unexpected", {instr_pc, instr}, 64'h0);
        else begin
          logic [63:0] e;
          e = exp_q.pop_front();
          check("instr_pair", {instr_pc, instr}, e);
          $display("instr pc=%h data=%h", instr_pc, instr);
        end
      end
      if (dbg_ack) begin
        if (dbg_q.size() == 0) check("dbg_unexpected_ack", {32'h0, dbg_data}, 64'h1);
        else begin
          logic [31:0] d;
          d = dbg_q.pop_front();
          check("dbg_data", {32'h0, dbg_data}, {32'h0, d});
          $display("dbg ack data=%h", dbg_data);
        end
      end
      if (w_valid && (wexp_q.size() != 0)) begin
        logic [63:0] we;
        we = wexp_q.pop_front();
        check("wrap_pair", {w_instr_pc, w_instr}, we);
        $display("wrap pc=%h data=%h", w_instr_pc, w_instr);
      end
    end
  end

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 32'hC0DE0000 + 32'(i);
    for (int i = 0; i < 16; i++) rom2[i] = 32'hBEEF0000 + 32'(i);
    RST = 1'b1; instr_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    dbg_req = 1'b0; dbg_addr = 10'h0;
    repeat (3) @(posedge clk);
    mon_en = 1'b1;
    @(negedge clk);
    check("rst_valid", {63'h0, instr_valid}, 64'h0);
    check("rst_instr", {32'h0, instr}, 64'h0);
    check("rst_instr_pc", {32'h0, instr_pc}, 64'h0);
    check("rst_dbg", {31'h0, dbg_ack, dbg_data}, 64'h0);
    check("rst_rom_addr", {54'h0, rom_addr}, 64'h0);
    @(posedge clk); #1;

    for (int c = 0; c <= 28; c++) begin
      RST         = (c == 26);
      instr_ready = (c <= 4) || (c >= 12 && c <= 25);
      redirect    = (c == 5) || (c == 15);
      redirect_pc = (c == 15) ? 32'h43 : 32'h0;
      dbg_req     = (c >= 19 && c <= 25);
      dbg_addr    = (c == 25) ? 10'd7 : 10'd5;
      if (c == 0) begin
        exp_q.push_back({32'h0, 32'hC0DE0000}); exp_q.push_back({32'h4, 32'hC0DE0001});
        exp_q.push_back({32'h8, 32'hC0DE0002}); exp_q.push_back({32'hC, 32'hC0DE0003});
        wexp_q.push_back({32'h3C, 32'hBEEF000F}); wexp_q.push_back({32'h40, 32'hBEEF0000});
      end
      if (c == 5) begin
        exp_q.push_back({32'h0, 32'hC0DE0000}); exp_q.push_back({32'h4, 32'hC0DE0001});
        exp_q.push_back({32'h8, 32'hC0DE0002});
      end
      if (c == 15) begin
        exp_q.push_back({32'hC, 32'hC0DE0003});
        exp_q.push_back({32'h40, 32'hC0DE0010}); exp_q.push_back({32'h44, 32'hC0DE0011});
      end
      if (c == 19) begin
        exp_q.push_back({32'h48, 32'hC0DE0012}); exp_q.push_back({32'h4C, 32'hC0DE0013});
        exp_q.push_back({32'h50, 32'hC0DE0014}); exp_q.push_back({32'h54, 32'hC0DE0015});
      end
      if (c == 19 || c == 21 || c == 23) dbg_q.push_back(32'hC0DE0005);

      @(negedge clk);
      if (c == 0) begin
        check("lat_valid_c0", {63'h0, instr_valid}, 64'h0);
        check("wrap_idx_c0", {60'h0, w_rom_addr}, 64'hF);
      end
      if (c == 1) begin
        check("lat_valid_c1", {63'h0, instr_valid}, 64'h1);
        check("wrap_idx_c1", {60'h0, w_rom_addr}, 64'h0);
      end
      if (c == 6 || c == 16) check("redirect_gap", {63'h0, instr_valid}, 64'h0);
      if (c == 16) check("redirect_addr", {54'h0, rom_addr}, 64'h10);
      if (c >= 7 && c <= 11) check("stall_head", {31'h0, instr_valid, instr_pc, instr}, {31'h0, 1'b1, 32'h0, 32'hC0DE0000});
      if (c == 11) check("stall_pc_addr", {54'h0, rom_addr}, 64'h2);
      if (c >= 19 && c <= 24) check("dbg_ack_pattern", {63'h0, dbg_ack}, {63'h0, 1'((c - 19) % 2)});
      if (c == 19) check("dbg_grant_addr", {54'h0, rom_addr}, 64'h5);
      if (c == 20) check("ack_fetch_addr", {54'h0, rom_addr}, 64'h13);
      if (c == 26) check("rst_no_ack", {63'h0, dbg_ack}, 64'h0);
      if (c == 27) begin
        check("post_rst_valid", {63'h0, instr_valid}, 64'h0);
        check("post_rst_head", {instr_pc, instr}, 64'h0);
        check("post_rst_dbg", {31'h0, dbg_ack, dbg_data}, 64'h0);
        check("post_rst_pc", {54'h0, rom_addr}, 64'h0);
      end
      @(posedge clk); #1;
    end

    check("instr_left", 64'(exp_q.size()), 64'h0);
    check("dbg_left", 64'(dbg_q.size()), 64'h0);
    check("wrap_left", 64'(wexp_q.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
